// File: rtl/stream_compare_track_if.sv
// ----------------------------------------------------------------------------
// stream_compare_track_if
// Bundles the operand stream, the result stream and the tracker/counter
// outputs of stream_compare_track. The master side is the producer/consumer
// environment; the slave side is the comparator block itself.
// ----------------------------------------------------------------------------
interface stream_compare_track_if #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 8
);
    // operand stream
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             clear;

    // result stream
    logic             out_valid;
    logic             out_ready;
    logic             lt;
    logic             ltu;
    logic             eq;
    logic             gt;
    logic             gtu;
    logic             sel_lt;

    // running statistics
    logic             seen;
    logic [WIDTH-1:0] min_val;
    logic [WIDTH-1:0] max_val;
    logic             trk_signed;
    logic [CNT_W-1:0] lt_count;
    logic [CNT_W-1:0] eq_count;

    modport master (
        output in_valid, a, b, signed_mode, clear, out_ready,
        input  in_ready, out_valid, lt, ltu, eq, gt, gtu, sel_lt,
        input  seen, min_val, max_val, trk_signed, lt_count, eq_count
    );

    modport slave (
        input  in_valid, a, b, signed_mode, clear, out_ready,
        output in_ready, out_valid, lt, ltu, eq, gt, gtu, sel_lt,
        output seen, min_val, max_val, trk_signed, lt_count, eq_count
    );
endinterface

// File: rtl/stream_compare_track.sv
// ----------------------------------------------------------------------------
// stream_compare_track
// One-stage pipelined comparator on a valid/ready stream of (a, b) pairs,
// producing signed/unsigned relational flags, plus a running min/max tracker
// of the a-stream whose signedness is latched when the tracker is seeded.
//
// Optional feature: define CMP_COUNT_EN to build saturating lt/eq event
// counters. Without it lt_count/eq_count are tied to zero.
//
// WIDTH/CNT_W must match the parameters of the connected interface.
// ----------------------------------------------------------------------------
module stream_compare_track #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    stream_compare_track_if.slave  bus
);

    typedef enum logic {
        ST_EMPTY    = 1'b0,
        ST_TRACKING = 1'b1
    } state_t;

    // Strict less-than in the requested signedness.
    function automatic logic less_than(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             sgn
    );
        logic signed [WIDTH-1:0] xs;
        logic signed [WIDTH-1:0] ys;
        xs = x;
        ys = y;
        return sgn ? (xs < ys) : (x < y);
    endfunction

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_run;
    logic r_vld_p1;
    logic w_in_ready;
    logic w_accept;

    // in_ready is held low during reset and for the release edge itself.
    assign w_in_ready = r_run & (~r_vld_p1 | bus.out_ready);
    assign w_accept   = bus.in_valid & w_in_ready;

    // Arm the input side on the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_run <= 1'b0;
        else        r_run <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Stage p0: combinational flag evaluation on the incoming pair
    // ------------------------------------------------------------------
    logic signed [WIDTH-1:0] w_a_s;
    logic signed [WIDTH-1:0] w_b_s;
    logic                    w_lt;
    logic                    w_ltu;
    logic                    w_eq;
    logic                    w_gt;
    logic                    w_gtu;
    logic                    w_sel_lt;

    assign w_a_s    = bus.a;
    assign w_b_s    = bus.b;
    assign w_lt     = (w_a_s < w_b_s);
    assign w_gt     = (w_a_s > w_b_s);
    assign w_ltu    = (bus.a < bus.b);
    assign w_gtu    = (bus.a > bus.b);
    assign w_eq     = (bus.a == bus.b);
    assign w_sel_lt = bus.signed_mode ? w_lt : w_ltu;

    // ------------------------------------------------------------------
    // Stage p1: result register, held while downstream stalls
    // ------------------------------------------------------------------
    logic r_lt_p1;
    logic r_ltu_p1;
    logic r_eq_p1;
    logic r_gt_p1;
    logic r_gtu_p1;
    logic r_sel_lt_p1;

    // Result valid: set on accept, dropped once the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             r_vld_p1 <= 1'b0;
        else if (w_accept)      r_vld_p1 <= 1'b1;
        else if (bus.out_ready) r_vld_p1 <= 1'b0;
    end

    // Capture the flags only on accept so a stalled result stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lt_p1     <= 1'b0;
            r_ltu_p1    <= 1'b0;
            r_eq_p1     <= 1'b0;
            r_gt_p1     <= 1'b0;
            r_gtu_p1    <= 1'b0;
            r_sel_lt_p1 <= 1'b0;
        end else if (w_accept) begin
            r_lt_p1     <= w_lt;
            r_ltu_p1    <= w_ltu;
            r_eq_p1     <= w_eq;
            r_gt_p1     <= w_gt;
            r_gtu_p1    <= w_gtu;
            r_sel_lt_p1 <= w_sel_lt;
        end
    end

    // ------------------------------------------------------------------
    // Tracker FSM (min/max of the a-stream)
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_min;
    logic [WIDTH-1:0] r_max;
    logic             r_trk_signed;
    logic [WIDTH-1:0] w_min_nxt;
    logic [WIDTH-1:0] w_max_nxt;
    logic             w_trk_signed_nxt;

    // Tracker state and extrema registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_EMPTY;
            r_min        <= '0;
            r_max        <= '0;
            r_trk_signed <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_min        <= w_min_nxt;
            r_max        <= w_max_nxt;
            r_trk_signed <= w_trk_signed_nxt;
        end
    end

    // Next-state: seed on first accept (or clear+accept), update on strict
    // extremes in the latched mode, wipe on a bare clear.
    always_comb begin
        w_state_nxt      = r_state;
        w_min_nxt        = r_min;
        w_max_nxt        = r_max;
        w_trk_signed_nxt = r_trk_signed;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt      = ST_TRACKING;
                    w_min_nxt        = bus.a;
                    w_max_nxt        = bus.a;
                    w_trk_signed_nxt = bus.signed_mode;
                end
            end
            ST_TRACKING: begin
                if (bus.clear && w_accept) begin
                    w_min_nxt        = bus.a;
                    w_max_nxt        = bus.a;
                    w_trk_signed_nxt = bus.signed_mode;
                end else if (bus.clear) begin
                    w_state_nxt      = ST_EMPTY;
                    w_min_nxt        = '0;
                    w_max_nxt        = '0;
                    w_trk_signed_nxt = 1'b0;
                end else if (w_accept) begin
                    if (less_than(bus.a, r_min, r_trk_signed)) w_min_nxt = bus.a;
                    if (less_than(r_max, bus.a, r_trk_signed)) w_max_nxt = bus.a;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Optional event counters
    // ------------------------------------------------------------------
`ifdef CMP_COUNT_EN
    // Increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic [CNT_W-1:0] r_lt_cnt;
    logic [CNT_W-1:0] r_eq_cnt;

    // Counters restart from the current pair when cleared on an accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lt_cnt <= '0;
            r_eq_cnt <= '0;
        end else if (bus.clear) begin
            r_lt_cnt <= {{(CNT_W-1){1'b0}}, w_accept & w_sel_lt};
            r_eq_cnt <= {{(CNT_W-1){1'b0}}, w_accept & w_eq};
        end else if (w_accept) begin
            if (w_sel_lt) r_lt_cnt <= sat_inc(r_lt_cnt);
            if (w_eq)     r_eq_cnt <= sat_inc(r_eq_cnt);
        end
    end

    assign bus.lt_count = r_lt_cnt;
    assign bus.eq_count = r_eq_cnt;
`else
    assign bus.lt_count = '0;
    assign bus.eq_count = '0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_vld_p1;
    assign bus.lt         = r_lt_p1;
    assign bus.ltu        = r_ltu_p1;
    assign bus.eq         = r_eq_p1;
    assign bus.gt         = r_gt_p1;
    assign bus.gtu        = r_gtu_p1;
    assign bus.sel_lt     = r_sel_lt_p1;
    assign bus.seen       = (r_state == ST_TRACKING);
    assign bus.min_val    = r_min;
    assign bus.max_val    = r_max;
    assign bus.trk_signed = r_trk_signed;

endmodule

// File: tb/tb_stream_compare_track.sv
// ----------------------------------------------------------------------------
// tb_stream_compare_track
// Directed bench with a result scoreboard and a reference tracker/counter
// model. Counter expectations follow CMP_COUNT_EN.
// ----------------------------------------------------------------------------
module tb_stream_compare_track;

    localparam int W  = 6;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    stream_compare_track_if #(.WIDTH(W), .CNT_W(CW)) u_if ();

    stream_compare_track #(.WIDTH(W), .CNT_W(CW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    typedef struct packed {
        logic lt;
        logic ltu;
        logic eq;
        logic gt;
        logic gtu;
        logic sel_lt;
    } exp_t;

    exp_t q[$];

    int ntests = 0;
    int nfail  = 0;

    // reference model state
    bit         m_run;
    bit         m_ov;
    bit         m_seen;
    bit         m_ts;
    logic [W-1:0] m_min;
    logic [W-1:0] m_max;
    int         m_ltc;
    int         m_eqc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntests++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    // two's complement value of a W-bit pattern
    function automatic int sv(input logic [W-1:0] x);
        return x[W-1] ? int'(x) - (1 << W) : int'(x);
    endfunction

    function automatic exp_t mk(input bit lt, ltu, eq, gt, gtu, sel);
        exp_t e;
        e.lt = lt; e.ltu = ltu; e.eq = eq; e.gt = gt; e.gtu = gtu; e.sel_lt = sel;
        return e;
    endfunction

    function automatic exp_t calc(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm);
        bit slt, ult;
        slt = sv(a) < sv(b);
        ult = int'(a) < int'(b);
        return mk(slt, ult, a == b, sv(a) > sv(b), int'(a) > int'(b), sm ? slt : ult);
    endfunction

    function automatic bit mless(input logic [W-1:0] x, input logic [W-1:0] y, input bit sgn);
        return sgn ? (sv(x) < sv(y)) : (int'(x) < int'(y));
    endfunction

    function automatic int exp_cnt(input int c);
`ifdef CMP_COUNT_EN
        return c;
`else
        return 0 * c;
`endif
    endfunction

    task automatic check_flags(input string tag, input exp_t e);
        exp_t o;
        o = mk(u_if.lt, u_if.ltu, u_if.eq, u_if.gt, u_if.gtu, u_if.sel_lt);
        check(tag, 32'(o), 32'(e));
    endtask

    task automatic check_trk();
        check("seen",       32'(u_if.seen),       32'(m_seen));
        check("min_val",    32'(u_if.min_val),    32'(m_min));
        check("max_val",    32'(u_if.max_val),    32'(m_max));
        check("trk_signed", 32'(u_if.trk_signed), 32'(m_ts));
        check("lt_count",   32'(u_if.lt_count),   32'(exp_cnt(m_ltc)));
        check("eq_count",   32'(u_if.eq_count),   32'(exp_cnt(m_eqc)));
    endtask

    task automatic reset_model();
        q.delete();
        m_run = 0; m_ov = 0; m_seen = 0; m_ts = 0;
        m_min = '0; m_max = '0; m_ltc = 0; m_eqc = 0;
    endtask

    // One clock of stimulus: called just after a falling edge, returns just
    // after the next falling edge with the tracker state compared.
    task automatic tick(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit sm, input bit clr, input bit ordy);
        bit   acc;
        exp_t e;
        u_if.in_valid    = v;
        u_if.a           = a;
        u_if.b           = b;
        u_if.signed_mode = sm;
        u_if.clear       = clr;
        u_if.out_ready   = ordy;
        #1;
        check("in_ready",  32'(u_if.in_ready),  32'(m_run && (!m_ov || ordy)));
        check("out_valid", 32'(u_if.out_valid), 32'(m_ov));
        if (m_ov) begin
            check("sb_has_entry", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                check_flags("result", q[0]);
                if (ordy) void'(q.pop_front());
            end
        end
        acc = v && m_run && (!m_ov || ordy);
        e   = calc(a, b, sm);
        if (acc) q.push_back(e);
        // tracker
        if (acc && (clr || !m_seen)) begin
            m_seen = 1; m_min = a; m_max = a; m_ts = sm;
        end else if (clr) begin
            m_seen = 0; m_min = '0; m_max = '0; m_ts = 0;
        end else if (acc) begin
            if (mless(a, m_min, m_ts)) m_min = a;
            if (mless(m_max, a, m_ts)) m_max = a;
        end
        // counters
        if (clr) begin
            m_ltc = (acc && e.sel_lt) ? 1 : 0;
            m_eqc = (acc && e.eq) ? 1 : 0;
        end else if (acc) begin
            if (e.sel_lt && m_ltc < (1 << CW) - 1) m_ltc++;
            if (e.eq && m_eqc < (1 << CW) - 1) m_eqc++;
        end
        m_ov = acc ? 1'b1 : (ordy ? 1'b0 : m_ov);
        @(posedge clk);
        @(negedge clk);
        check_trk();
    endtask

    initial begin
        rst_n            = 1'b0;
        u_if.in_valid    = 1'b0;
        u_if.a           = '0;
        u_if.b           = '0;
        u_if.signed_mode = 1'b0;
        u_if.clear       = 1'b0;
        u_if.out_ready   = 1'b0;
        reset_model();

        // reset state
        @(negedge clk);
        check("rst_out_valid", 32'(u_if.out_valid), 32'd0);
        check("rst_in_ready",  32'(u_if.in_ready),  32'd0);
        check_flags("rst_flags", mk(0, 0, 0, 0, 0, 0));
        check_trk();
        rst_n = 1'b1;
        @(negedge clk);
        m_run = 1;
        u_if.out_ready = 1'b1;
        #1;
        check("in_ready_after_release", 32'(u_if.in_ready), 32'd1);
        @(negedge clk);

        // 1: signed -1 vs 1
        tick(1, 6'h3F, 6'h01, 1, 0, 1);
        check_flags("t1_flags", mk(1, 0, 0, 0, 1, 1));
        tick(0, 6'h00, 6'h00, 0, 0, 1);

        // 2: backpressure with a held second pair
        tick(1, 6'h05, 6'h05, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1, 6'h02, 6'h07, 1, 0, 0);
            check("t2_eq_hold",    32'(u_if.eq),       32'd1);
            check("t2_ready_low",  32'(u_if.in_ready), 32'd0);
        end
        tick(1, 6'h02, 6'h07, 1, 0, 1);
        check_flags("t2_second", mk(1, 1, 0, 0, 0, 1));
        tick(0, 6'h00, 6'h00, 0, 0, 1);
        check("t2_drained", 32'(q.size()), 32'd0);

        // 3: tracker signed, then unsigned
        tick(1, 6'h05, 6'h00, 1, 1, 1);
        tick(1, 6'h3F, 6'h00, 1, 0, 1);
        tick(1, 6'h20, 6'h00, 1, 0, 1);
        check("t3s_min", 32'(u_if.min_val),    32'h20);
        check("t3s_max", 32'(u_if.max_val),    32'h05);
        check("t3s_ts",  32'(u_if.trk_signed), 32'd1);
        tick(1, 6'h05, 6'h00, 0, 1, 1);
        tick(1, 6'h3F, 6'h00, 0, 0, 1);
        tick(1, 6'h20, 6'h00, 0, 0, 1);
        check("t3u_min", 32'(u_if.min_val), 32'h05);
        check("t3u_max", 32'(u_if.max_val), 32'h3F);

        // 4: mode latch and clear
        tick(1, 6'h05, 6'h00, 1, 1, 1);
        tick(1, 6'h30, 6'h00, 0, 0, 1);
        check("t4_latch_min", 32'(u_if.min_val), 32'h30);
        tick(0, 6'h00, 6'h00, 0, 1, 1);
        check("t4_clr_seen", 32'(u_if.seen),    32'd0);
        check("t4_clr_min",  32'(u_if.min_val), 32'd0);
        tick(1, 6'h0A, 6'h00, 0, 1, 1);
        check("t4_reseed_min", 32'(u_if.min_val),    32'h0A);
        check("t4_reseed_max", 32'(u_if.max_val),    32'h0A);
        check("t4_reseed_ts",  32'(u_if.trk_signed), 32'd0);
        tick(0, 6'h00, 6'h00, 0, 0, 1);

        // 5: counters saturate at 3, clear zeroes them
        tick(0, 6'h00, 6'h00, 0, 1, 1);
        for (int i = 0; i < 5; i++) tick(1, 6'h01, 6'h02, 1, 0, 1);
        tick(1, 6'h07, 6'h07, 1, 0, 1);
        check("t5_ltc", 32'(u_if.lt_count), 32'(exp_cnt(3)));
        check("t5_eqc", 32'(u_if.eq_count), 32'(exp_cnt(1)));
        tick(0, 6'h00, 6'h00, 0, 1, 1);
        check("t5_ltc_clr", 32'(u_if.lt_count), 32'd0);

        // 6: async reset while a result is stalled
        tick(1, 6'h11, 6'h22, 1, 0, 0);
        check("t6_ov_before", 32'(u_if.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        reset_model();
        check("t6_ov",       32'(u_if.out_valid), 32'd0);
        check("t6_in_ready", 32'(u_if.in_ready),  32'd0);
        check_flags("t6_flags", mk(0, 0, 0, 0, 0, 0));
        check_trk();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m_run = 1;
        tick(1, 6'h2A, 6'h15, 0, 0, 1);
        check_flags("t6_first", mk(1, 0, 0, 0, 1, 0));
        tick(0, 6'h00, 6'h00, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    // Safety bound on total run time.
    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
